fb_scanout: RTL and testbench
=============================

Name: fb_scanout

Overview:
- Display-side end of the pixel write port (cpu_wr/cpu_addr/cpu_data) that the font/text renderer drives.
- Accepts 8-bit grayscale pixel writes into an on-chip 640x480 framebuffer.
- Generates 640x480@60 VGA timing on pclk and scans the framebuffer out as r/g/b with blanking, sync and DE for the MiSTer video path.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch (line total 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch (frame total 525)
- PIXEL_COUNT, 307200, framebuffer depth (H_ACTIVE*V_ACTIVE)

Ports:
- pclk  in  1  pixel clock; also the write-port clock
- reset  in  1  asynchronous, active-high reset
- cpu_wr  in  1  pixel write strobe, one pixel per cycle
- cpu_addr  in  32  linear pixel address, y*640+x
- cpu_data  in  8  pixel intensity
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- r  out  8  red
- g  out  8  green
- b  out  8  blue
- VGA_HB  out  1  horizontal blank, high outside the active columns
- VGA_VB  out  1  vertical blank, high outside the active lines
- VGA_DE  out  1  data enable, equal to ~VGA_HB & ~VGA_VB
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Interface (decided): one clock, pclk. Reset is asynchronous and active-high on port reset.
- Reset values: hcnt=0, vcnt=0, rd_ptr=0, hs=1, vs=1, VGA_HB=1, VGA_VB=1, VGA_DE=0, r=g=b=0, frame_start=0. The framebuffer contents are not cleared.
- hcnt counts 0..799 and wraps to 0. vcnt increments when hcnt wraps, counts 0..524 and wraps to 0.
- Raw timing, stage 0:
  - hact = hcnt<640, vact = vcnt<480
  - hs_n low for 656<=hcnt<752
  - vs_n low for 490<=vcnt<492
- Read pointer rd_ptr, 19 bits:
  - cleared when hcnt=799 and vcnt=524 (start of the next frame)
  - otherwise increments by 1 on every cycle where hact&vact
  - no multiplier is used
- Pipeline, fixed latency of 2 pclk:
  - stage 1 registers the RAM read address (rd_ptr) plus hs_n, vs_n, ~hact, ~vact and first-pixel flag
  - stage 2 registers the RAM output and the delayed timing signals
  - all outputs change on the same edge, two cycles after the counters hold (h,v)
- Output values: r=g=b=pixel when DE=1, else 0.
- frame_start is 1 exactly when the output pixel is (0,0).
- Write port:
  - when cpu_wr=1 and cpu_addr<PIXEL_COUNT, write cpu_data to mem[cpu_addr[18:0]] on that edge
  - when cpu_addr>=PIXEL_COUNT, the write is dropped silently and no address aliasing occurs
  - writes are accepted every cycle, including during reset, and are independent of the scan position
- Read-during-write to the same address returns the old data. The new value appears on the next frame.
- Reset mid-frame:
  - outputs return to reset values asynchronously
  - after release, scanning restarts at (0,0)
  - the first valid pixel appears 2 cycles after the first edge with reset low
- No state machine beyond the counters. Counters must never reach illegal values.

Decomposition:
- Package fb_pkg:
  - timing constants (the H_*/V_* defaults and derived totals 800/525)
  - sync start/end constants
  - PIXEL_COUNT and address width 19
  - pixel typedef (8-bit)
  - sync-polarity constant (active low)
- Sub-module fb_ram:
  - simple dual-port RAM, 307200x8
  - one write port, one registered read port, single clock
  - old-data read-during-write
  - inferable to block RAM

Test Plan:
- Reset: hold reset 5 cycles mid-frame -> hs=vs=1, HB=VB=1, DE=0, r=g=b=0 immediately. frame_start pulses 2 cycles after release.
- Timing: run 2 frames -> 800 cycles per line, 525 lines per frame. hs low 96 cycles starting 658 cycles after line start (656+2). vs low for 2 lines. DE high for 640 cycles per line on 480 lines. DE count per frame = 307200.
- Write then scan:
  - write 0x5A to addr 0, 0xC3 to addr 639, 0x11 to addr 640, 0xFF to addr 307199 before the frame
  - r=g=b on output pixels (0,0), (639,0), (0,1), (639,479) equal those values
  - all outputs are 0 during blanking
- Out-of-range write: write 0x77 at addr 307200 and 0x88 at addr 0x80000 -> no framebuffer location changes; addr 0 still reads back 0x5A.
- Collision: write 0x99 to addr 1000 in the same cycle it is read -> this frame shows the old value at (360,1); the next frame shows 0x99.
- Back-to-back writes: 640 consecutive cpu_wr cycles to line 10, values x&0xFF -> line 10 scans out as a ramp 0..255,0..255,0..127.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
// Shared timing defaults, widths and pixel type for the framebuffer scan-out slice.
// Defaults describe 640x480@60 VGA; the top module takes them as overridable parameters.
package fb_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;  // 800
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;  // 525
  localparam int HS_START_D = H_ACTIVE_D + H_FP_D;
  localparam int HS_END_D   = HS_START_D + H_SYNC_D;
  localparam int VS_START_D = V_ACTIVE_D + V_FP_D;
  localparam int VS_END_D   = VS_START_D + V_SYNC_D;

  localparam int PIXEL_COUNT = H_ACTIVE_D * V_ACTIVE_D;
  localparam int ADDR_W      = 19;
  localparam int CNT_W       = 10;

  // Both syncs are active low.
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef logic [7:0] pixel_t;

endpackage

// File: rtl/fb_scanout_if.sv
// Pixel write port driven by the text renderer: one pixel per cycle at a linear address.
interface fb_wr_if;
  logic           cpu_wr;
  logic [31:0]    cpu_addr;
  fb_pkg::pixel_t cpu_data;

  modport master (output cpu_wr, cpu_addr, cpu_data);
  modport slave  (input  cpu_wr, cpu_addr, cpu_data);
endinterface

// File: rtl/fb_scanout_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// Reading the address being written returns the previous contents.
module fb_ram
  import fb_pkg::*;
#(
  parameter int DEPTH = PIXEL_COUNT,
  parameter int AW    = ADDR_W
) (
  input  logic          pclk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  pixel_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output pixel_t        rd_data
);

  pixel_t mem [DEPTH];

  always_ff @(posedge pclk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fb_scanout.sv
// VGA timing generator and framebuffer scan-out with a fixed two-cycle pipeline
// from the h/v counters to every video output.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic   pclk,
  input  logic   reset,
  fb_wr_if.slave wr,
  output logic   hs,
  output logic   vs,
  output pixel_t r,
  output pixel_t g,
  output pixel_t b,
  output logic   VGA_HB,
  output logic   VGA_VB,
  output logic   VGA_DE,
  output logic   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIX     = H_ACTIVE * V_ACTIVE;
  localparam int RAM_AW  = $clog2(PIX);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0]      PIX_LIMIT = 32'(PIX);

  logic [CNT_W-1:0]  hcnt_reg, vcnt_reg;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_addr_reg;
  logic              hact, vact, hs_n, vs_n, frame_end, wr_en;
  logic              hs1_reg, vs1_reg, hb1_reg, vb1_reg, first1_reg;
  logic              de_reg;
  pixel_t            ram_q;
  pixel_t            chan [3];

  always_comb begin
    hact      = hcnt_reg < H_ACT;
    vact      = vcnt_reg < V_ACT;
    hs_n      = (hcnt_reg >= HS_BEG && hcnt_reg < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_n      = (vcnt_reg >= VS_BEG && vcnt_reg < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_end = (hcnt_reg >= H_LAST) && (vcnt_reg >= V_LAST);
    // Full 32-bit compare so out-of-range addresses can never alias into the RAM.
    wr_en     = wr.cpu_wr && (wr.cpu_addr < PIX_LIMIT);
  end

  // Wrap on >= so a corrupted counter always falls back into range.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hcnt_reg   <= '0;
      vcnt_reg   <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (hcnt_reg >= H_LAST) begin
        hcnt_reg <= '0;
        vcnt_reg <= (vcnt_reg >= V_LAST) ? '0 : vcnt_reg + CNT_W'(1);
      end else begin
        hcnt_reg <= hcnt_reg + CNT_W'(1);
      end
      if (frame_end) begin
        rd_ptr_reg <= '0;
      end else if (hact && vact) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
    end
  end

  // Stage 1: RAM address plus timing; blanked cycles park the address at 0.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      rd_addr_reg <= '0;
      hs1_reg     <= ~SYNC_ACTIVE;
      vs1_reg     <= ~SYNC_ACTIVE;
      hb1_reg     <= 1'b1;
      vb1_reg     <= 1'b1;
      first1_reg  <= 1'b0;
    end else begin
      rd_addr_reg <= (hact && vact) ? rd_ptr_reg : '0;
      hs1_reg     <= hs_n;
      vs1_reg     <= vs_n;
      hb1_reg     <= ~hact;
      vb1_reg     <= ~vact;
      first1_reg  <= (hcnt_reg == '0) && (vcnt_reg == '0);
    end
  end

  // Stage 2: aligned with the RAM output register.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hs          <= ~SYNC_ACTIVE;
      vs          <= ~SYNC_ACTIVE;
      VGA_HB      <= 1'b1;
      VGA_VB      <= 1'b1;
      de_reg      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hs          <= hs1_reg;
      vs          <= vs1_reg;
      VGA_HB      <= hb1_reg;
      VGA_VB      <= vb1_reg;
      de_reg      <= ~hb1_reg & ~vb1_reg;
      frame_start <= first1_reg;
    end
  end

  fb_ram #(
    .DEPTH (PIX),
    .AW    (RAM_AW)
  ) u_ram (
    .pclk    (pclk),
    .we      (wr_en),
    .wr_addr (wr.cpu_addr[RAM_AW-1:0]),
    .wr_data (wr.cpu_data),
    .rd_addr (rd_addr_reg[RAM_AW-1:0]),
    .rd_data (ram_q)
  );

  // RAM output is not reset, so gating by DE is what zeroes colour in reset and blanking.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign chan[gi] = de_reg ? ram_q : '0;
  end

  assign r      = chan[0];
  assign g      = chan[1];
  assign b      = chan[2];
  assign VGA_DE = de_reg;

endmodule

// File: tb/tb_fb_scanout.sv
// Randomized bench for fb_scanout on a shrunken raster, checked each cycle against a
// model that derives the expected output from elapsed cycles and a shadow framebuffer.
module tb_fb_scanout;

  localparam int HA = 32, HF = 4, HSY = 8, HBP = 4;
  localparam int VA = 24, VF = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HF + HSY + HBP;
  localparam int VT = VA + VF + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int PIX = HA * VA;
  localparam logic [31:0] RESET_VEC = {2'b00, 6'b111100, 24'h000000};

  logic pclk = 1'b0;
  logic reset = 1'b0;
  logic hs, vs, VGA_HB, VGA_VB, VGA_DE, frame_start;
  logic [7:0] r, g, b;
  logic [31:0] obs_vec;

  always #5 pclk = ~pclk;

  fb_wr_if bus ();

  fb_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSY), .V_BP (VBP)
  ) dut (
    .pclk        (pclk),
    .reset       (reset),
    .wr          (bus),
    .hs          (hs),
    .vs          (vs),
    .r           (r),
    .g           (g),
    .b           (b),
    .VGA_HB      (VGA_HB),
    .VGA_VB      (VGA_VB),
    .VGA_DE      (VGA_DE),
    .frame_start (frame_start)
  );

  assign obs_vec = {2'b00, hs, vs, VGA_HB, VGA_VB, VGA_DE, frame_start, r, g, b};

  int n_checks = 0;
  int n_fail = 0;
  byte unsigned fbm [PIX];
  int m = 0;
  int cur_h = 0, cur_v = 0;
  bit cur_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the output after the m-th edge out of reset shows raster step m-2.
  initial begin
    logic [31:0] exp_vec;
    int t, h, v, flen, dcnt, hlo, vlo;
    bit de, sv;
    byte unsigned pix;
    sv = 1'b0; flen = 0; dcnt = 0; hlo = 0; vlo = 0;
    forever begin
      @(posedge pclk);
      if (reset) begin
        m = 0; cur_valid = 1'b0; exp_vec = RESET_VEC; sv = 1'b0;
      end else begin
        m++;
        if (m < 2) begin
          exp_vec = RESET_VEC; cur_valid = 1'b0;
        end else begin
          t = m - 2;
          h = t % HT;
          v = (t / HT) % VT;
          de = (h < HA) && (v < VA);
          pix = 8'h00;
          if (de) pix = fbm[v * HA + h];
          exp_vec = {2'b00, !(h >= HA + HF && h < HA + HF + HSY), !(v >= VA + VF && v < VA + VF + VSY),
                     (h >= HA), (v >= VA), de, (h == 0 && v == 0), pix, pix, pix};
          cur_h = h; cur_v = v; cur_valid = 1'b1;
        end
      end
      if (bus.cpu_wr && bus.cpu_addr < 32'(PIX)) fbm[bus.cpu_addr] = bus.cpu_data;
      #1;
      check_eq("scan", obs_vec, exp_vec);
      if (frame_start) begin
        if (sv) begin
          check_eq("frame_len", 32'(flen), 32'(FRAME));
          check_eq("de_per_frame", 32'(dcnt), 32'(PIX));
          check_eq("hs_low_per_frame", 32'(hlo), 32'(HSY * VT));
          check_eq("vs_low_per_frame", 32'(vlo), 32'(VSY * HT));
          $display("FRAME len=%0d de=%0d hs_low=%0d vs_low=%0d", flen, dcnt, hlo, vlo);
        end
        flen = 0; dcnt = 0; hlo = 0; vlo = 0; sv = 1'b1;
      end
      flen++;
      dcnt += int'(VGA_DE);
      hlo += int'(!hs);
      vlo += int'(!vs);
    end
  end

  task automatic drive(input bit we, input int unsigned addr, input byte unsigned data);
    @(negedge pclk);
    bus.cpu_wr = we;
    bus.cpu_addr = addr;
    bus.cpu_data = data;
  endtask

  task automatic write_txn(input int unsigned addr, input byte unsigned data);
    drive(1'b1, addr, data);
    $display("WR addr=%0h data=%02h", addr, data);
  endtask

  task automatic wait_pos(input int h, input int v);
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(posedge pclk);
      #2;
      if (cur_valid && cur_h == h && cur_v == v) return;
    end
    check_eq("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic probe(input string tag, input int h, input int v, input byte unsigned exp);
    wait_pos(h, v);
    check_eq(tag, {8'h00, r, g, b}, {8'h00, exp, exp, exp});
    $display("PROBE %s (%0d,%0d) r=%02h", tag, h, v, r);
  endtask

  task automatic random_writes(input int cycles);
    int nw;
    nw = 0;
    for (int k = 0; k < cycles; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        drive(1'b1, $urandom_range(0, PIX + 40), 8'($urandom));
        nw++;
      end else begin
        drive(1'b0, 0, 8'h00);
      end
    end
    drive(1'b0, 0, 8'h00);
    $display("RAND %0d writes over %0d cycles", nw, cycles);
  endtask

  initial begin
    bit found;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_data = '0;
    #1 reset = 1'b1;
    #1 check_eq("reset_state", obs_vec, RESET_VEC);

    // Fill the whole framebuffer during reset so every read is defined.
    for (int a = 0; a < PIX; a++) drive(1'b1, a, 8'($urandom));
    write_txn(0, 8'h5A);
    write_txn(HA - 1, 8'hC3);
    write_txn(HA, 8'h11);
    write_txn(PIX - 1, 8'hFF);
    write_txn(HA + 8, 8'h42);
    drive(1'b0, 0, 8'h00);
    @(negedge pclk) reset = 1'b0;
    @(posedge pclk);
    @(posedge pclk);
    #2 check_eq("fs_after_release", {31'd0, frame_start}, 32'd1);

    for (int x = 0; x < HA; x++) write_txn(10 * HA + x, 8'(x & 8'hFF));
    drive(1'b0, 0, 8'h00);

    probe("px_0_0", 0, 0, 8'h5A);
    probe("px_last_col", HA - 1, 0, 8'hC3);
    probe("px_0_1", 0, 1, 8'h11);
    probe("px_pre_collide", 8, 1, 8'h42);
    probe("blank_h", 40, 5, 8'h00);
    probe("ramp_0", 0, 10, 8'h00);
    probe("ramp_16", 16, 10, 8'h10);
    probe("ramp_last", HA - 1, 10, 8'(HA - 1));
    probe("px_last", HA - 1, VA - 1, 8'hFF);
    probe("blank_v", 3, VA + 1, 8'h00);

    write_txn(PIX, 8'h77);
    write_txn(32'h0008_0000, 8'h88);
    write_txn(1024, 8'h66);
    write_txn(32'hFFFF_FFFF, 8'h55);
    drive(1'b0, 0, 8'h00);
    probe("oob_keep_0", 0, 0, 8'h5A);

    // Write (8,1) on the very edge that reads it: this frame shows the old byte.
    found = 1'b0;
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      @(negedge pclk);
      if (!reset && m >= 1 && ((m - 1) % FRAME) == HT + 8) begin
        bus.cpu_wr = 1'b1; bus.cpu_addr = HA + 8; bus.cpu_data = 8'h99;
        found = 1'b1;
      end
    end
    check_eq("collide_found", {31'd0, found}, 32'd1);
    @(posedge pclk);
    #2 check_eq("collide_old", {24'd0, r}, 32'h42);
    $display("WR collide addr=%0h data=99 shown=%02h", HA + 8, r);
    drive(1'b0, 0, 8'h00);
    probe("collide_new", 8, 1, 8'h99);

    random_writes(FRAME);

    // Mid-frame asynchronous reset.
    @(posedge pclk);
    #3 reset = 1'b1;
    #1 check_eq("async_reset", obs_vec, RESET_VEC);
    write_txn(5, 8'hAB);
    drive(1'b0, 0, 8'h00);
    repeat (3) @(negedge pclk);
    reset = 1'b0;
    @(posedge pclk);
    @(posedge pclk);
    #2 check_eq("fs_restart", {31'd0, frame_start}, 32'd1);
    probe("wr_in_reset", 5, 0, 8'hAB);

    random_writes(2 * FRAME + 100);
    repeat (10) @(posedge pclk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
